inst_prefetch: RTL and testbench

INST_PREFETCH -- requirements
Module: inst_prefetch

---
 rtl/akarin_pkg.sv | 10 +
 rtl/inst_prefetch_if.sv | 16 +
 rtl/fetch_fifo.sv | 42 ++++
 rtl/inst_prefetch.sv | 83 ++++++++
 tb/tb_inst_prefetch.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/akarin_pkg.sv
// akarin_pkg: widths and the fetch packet shared by fetch and decode
package akarin_pkg;
  localparam int PC_W = 30;
  localparam int INST_W = 32;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic valid;
  } packet_t;
endpackage

// File: rtl/inst_prefetch_if.sv
// inst_prefetch_if: instruction-memory read bus between prefetcher (master) and memory (slave)
// addr_o/read_o/write_o/byteSel_o/dataD_o: request from prefetcher
// dataQ_i/ready_i: in-order response data and strobe from memory
interface inst_prefetch_if
  import akarin_pkg::*;
();
  logic [PC_W-1:0] addr_o;
  logic read_o;
  logic write_o;
  logic [3:0] byteSel_o;
  logic [INST_W-1:0] dataD_o;
  logic [INST_W-1:0] dataQ_i;
  logic ready_i;
  modport master (output addr_o, read_o, write_o, byteSel_o, dataD_o, input dataQ_i, ready_i);
  modport slave (input addr_o, read_o, write_o, byteSel_o, dataD_o, output dataQ_i, ready_i);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: fetch packet queue feeding decode
// clk/rst: clock, async active-low reset
// push/din: enqueue a packet; pop: dequeue the head; flush: empty the queue
// head: oldest packet, valid set while not empty; count: occupancy 0..DEPTH
module fetch_fifo
  import akarin_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  packet_t din,
  input  logic pop,
  input  logic flush,
  output packet_t head,
  output logic [CW-1:0] count
);
  packet_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  assign head = '{pc: mem[rd].pc, inst: mem[rd].inst, valid: count != '0};
  // The issue credit keeps count+inflight within DEPTH, so a full queue never sees a push
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: credit-based instruction prefetcher with redirect flush and in-order response tagging
// clk/rst: clock, async active-low reset
// redirect_i/redirect_pc_i: flush and restart fetch at a new word address
// stall_i: decode cannot accept; valid_o/pc_o/inst_o: fetch packet to decode
// stop_o: queue empty while a live read is pending
// mem: memory read bus (master side)
module inst_prefetch
  import akarin_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic stall_i,
  output logic valid_o,
  output logic [PC_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic stop_o,
  inst_prefetch_if.master mem
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int IW = $clog2(MAX_OUT + 1);
  localparam int TW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  logic [PC_W-1:0] fetch_pc;
  logic [IW-1:0] inflight, drop, live;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  logic [PC_W-1:0] tags [MAX_OUT];
  logic [TW-1:0] tw, tr;
  logic issue, resp, push;
  packet_t head;
  function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] p);
    return p == TW'(MAX_OUT - 1) ? '0 : p + 1'b1;
  endfunction
  assign live = inflight - drop;
  assign occ = OW'(count) + OW'(live);
  // rst gates issue so read_o is low while reset is held
  assign issue = rst && !redirect_i && inflight < IW'(MAX_OUT) && occ < OW'(DEPTH);
  // A strobe with nothing outstanding is a stale pre-reset response and is ignored
  assign resp = mem.ready_i && inflight != '0;
  assign push = resp && drop == '0 && !redirect_i;
  assign stop_o = count == '0 && live != '0 && !redirect_i;
  assign mem.addr_o = fetch_pc;
  assign mem.read_o = issue;
  assign mem.write_o = 1'b0;
  assign mem.byteSel_o = 4'b1111;
  assign mem.dataD_o = '0;
  assign valid_o = head.valid;
  assign pc_o = head.pc;
  assign inst_o = head.inst;
  // Tags advance on every response, dropped or not, so they stay aligned with inflight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop <= '0;
      tw <= '0;
      tr <= '0;
    end else begin
      fetch_pc <= redirect_i ? redirect_pc_i : fetch_pc + PC_W'(issue);
      inflight <= inflight + IW'(issue) - IW'(resp);
      drop <= redirect_i ? inflight - IW'(resp) : drop - IW'(resp && drop != '0);
      if (issue) tw <= wrap_inc(tw);
      if (resp) tr <= wrap_inc(tr);
    end
  always_ff @(posedge clk)
    if (issue) tags[tw] <= fetch_pc;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din('{pc: tags[tr], inst: mem.dataQ_i, valid: 1'b1}),
    .pop(valid_o && !stall_i),
    .flush(redirect_i),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: directed checks of issue, stall, redirect, wrap and reset behaviour
module tb_inst_prefetch;
  import akarin_pkg::*;
  logic clk = 1'b0;
  logic rst, redirect, stall, hold, stray;
  logic [29:0] rpc;
  logic valid_o, stop_o;
  logic [29:0] pc_o;
  logic [31:0] inst_o;
  int checks = 0, errors = 0, cyc = 0;
  logic [29:0] mq_a [$];
  int mq_c [$];
  logic [29:0] issued [$];
  inst_prefetch_if bus ();
  inst_prefetch #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(30'h0)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(rpc), .stall_i(stall),
    .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .stop_o(stop_o), .mem(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] inst_of(input logic [29:0] pc);
    return {2'b10, pc};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    bus.ready_i = 1'b0;
    bus.dataQ_i = '0;
    if (!rst) begin
      mq_a.delete();
      mq_c.delete();
    end else if (stray) begin
      bus.ready_i = 1'b1;
      bus.dataQ_i = 32'hbad0bad0;
      stray = 1'b0;
    end else if (!hold && mq_a.size() > 0 && mq_c[0] < cyc) begin
      bus.ready_i = 1'b1;
      bus.dataQ_i = inst_of(mq_a[0]);
      void'(mq_a.pop_front());
      void'(mq_c.pop_front());
    end
    #1;
    if (rst && bus.read_o) begin
      mq_a.push_back(bus.addr_o);
      mq_c.push_back(cyc);
      issued.push_back(bus.addr_o);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask
  task automatic reset_dut();
    rst = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    hold = 1'b0;
    step();
    step();
    rst = 1'b1;
    issued.delete();
  endtask
  task automatic wait_valid(input int n);
    int i = 0;
    while (!valid_o && i < n) begin
      step();
      i++;
    end
    chk("wait_valid", valid_o, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    rst = 1'b1; redirect = 1'b0; rpc = '0; stall = 1'b0; hold = 1'b0; stray = 1'b0;
    bus.ready_i = 1'b0; bus.dataQ_i = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_read", bus.read_o, 0);
    chk("rst_stop", stop_o, 0);
    chk("rst_write", bus.write_o, 0);
    chk("rst_bsel", bus.byteSel_o, 4'hf);
    step();
    rst = 1'b1;
    issued.delete();
    #1;
    chk("first_read", bus.read_o, 1);
    chk("first_addr", bus.addr_o, 0);
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("seq_pc", {valid_o, pc_o}, {1'b1, 30'(k)});
      chk("seq_inst", inst_o, inst_of(30'(k)));
    end
    for (int k = 0; k < 4; k++) chk("seq_issue", issued[k], 64'(k));
    reset_dut();
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i > 0) chk("stall_hold", {valid_o, pc_o, inst_o}, {1'b1, 30'd0, inst_of(30'd0)});
    end
    chk("stall_issues", issued.size(), 4);
    chk("stall_read", bus.read_o, 0);
    stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("drain_pc", {valid_o, pc_o}, {1'b1, 30'(k)});
    end
    reset_dut();
    hold = 1'b1;
    redirect = 1'b1;
    rpc = 30'h8;
    step();
    redirect = 1'b0;
    step();
    step();
    #1;
    chk("fl_issue0", issued[0], 30'h8);
    chk("fl_issue1", issued[1], 30'h9);
    chk("fl_read", bus.read_o, 0);
    chk("fl_stop", stop_o, 1);
    redirect = 1'b1;
    rpc = 30'h100;
    #1;
    chk("redir_read", bus.read_o, 0);
    chk("redir_stop", stop_o, 0);
    step();
    redirect = 1'b0;
    hold = 1'b0;
    #1;
    chk("redir_drop", dut.drop, 2);
    chk("redir_stop_after", stop_o, 0);
    chk("redir_valid", valid_o, 0);
    wait_valid(20);
    chk("redir_pkt", {valid_o, pc_o, inst_o}, {1'b1, 30'h100, inst_of(30'h100)});
    chk("redir_drop0", dut.drop, 0);
    reset_dut();
    hold = 1'b1;
    redirect = 1'b1;
    rpc = 30'h20;
    step();
    redirect = 1'b0;
    step();
    step();
    hold = 1'b0;
    redirect = 1'b1;
    rpc = 30'h40;
    step();
    redirect = 1'b0;
    #1;
    chk("rr_drop", dut.drop, 1);
    wait_valid(20);
    chk("rr_pkt", {valid_o, pc_o, inst_o}, {1'b1, 30'h40, inst_of(30'h40)});
    reset_dut();
    redirect = 1'b1;
    rpc = 30'h3ffffffe;
    step();
    redirect = 1'b0;
    issued.delete();
    repeat (5) step();
    chk("wrap0", issued[0], 30'h3ffffffe);
    chk("wrap1", issued[1], 30'h3fffffff);
    chk("wrap2", issued[2], 30'h0);
    chk("wrap3", issued[3], 30'h1);
    chk("wrap_head", {valid_o, pc_o, inst_o}, {1'b1, 30'h1, inst_of(30'h1)});
    reset_dut();
    stall = 1'b1;
    repeat (3) step();
    hold = 1'b1;
    step();
    #1;
    chk("pre_rst_valid", valid_o, 1);
    chk("pre_rst_inflight", dut.inflight, 2);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_read", bus.read_o, 0);
    chk("mid_rst_stop", stop_o, 0);
    stall = 1'b0;
    hold = 1'b0;
    step();
    step();
    rst = 1'b1;
    issued.delete();
    stray = 1'b1;
    #1;
    chk("post_rst_read", bus.read_o, 1);
    chk("post_rst_addr", bus.addr_o, 0);
    wait_valid(20);
    chk("post_rst_pkt", {valid_o, pc_o, inst_o}, {1'b1, 30'h0, inst_of(30'h0)});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
